// File: rtl/decode_ctrl_pipe_if.sv
// Fetch-to-execute decode channel: fetch handshake, execute handshake and the decoded control fields.
// The master modport is the fetch/execute environment; the slave modport is the decoder itself.
interface decode_ctrl_pipe_if #(
  parameter int ALUOP_W = 5
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [31:0]        in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_pc;
  logic               illegal;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         alu_srca;
  logic               alu_srcb;
  logic [1:0]         mem_d_wdsrc;
  logic               mem_d_we;
  logic [2:0]         dataout_src;
  logic               reg_we;
  logic [3:0]         immg_op;
  logic [3:0]         bj_op;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, illegal, alu_op, alu_srca, alu_srcb,
           mem_d_wdsrc, mem_d_we, dataout_src, reg_we, immg_op, bj_op
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, illegal, alu_op, alu_srca, alu_srcb,
           mem_d_wdsrc, mem_d_we, dataout_src, reg_we, immg_op, bj_op
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// RV32I(+M) decoder, one register stage: 1-cycle latency, 1/cycle throughput for non-M ops.
// in_ready follows out_ready combinationally; held low while a multi-cycle M op occupies execute.
module decode_ctrl_pipe #(
  parameter int ENABLE_M = 0,
  parameter int MUL_LAT  = 1,
  parameter int DIV_LAT  = 32,
  parameter int ALUOP_W  = 5
) (
  input logic               clk,
  input logic               reset,
  decode_ctrl_pipe_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_FULL   = 2'd1;
  localparam logic [1:0] S_MCWAIT = 2'd2;

  localparam logic [ALUOP_W-1:0] EXE_ADD_OP  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] EXE_MUL_OP  = ALUOP_W'(11);

  localparam logic [1:0] SRCA_ZERO = 2'd0, SRCA_RRD1 = 2'd1, SRCA_PC = 2'd2;
  localparam logic       SRCB_RRD2 = 1'b0, SRCB_IMM = 1'b1;
  localparam logic [2:0] DOUT_ALU  = 3'd1, DOUT_PC4 = 3'd2, DOUT_LB = 3'd3;
  localparam logic [3:0] IMM_I = 4'd1, IMM_S = 4'd2, IMM_B = 4'd3, IMM_U = 4'd4, IMM_J = 4'd5;
  localparam logic [3:0] BJOP_JUMP = 4'd1, BJOP_BEQ = 4'd2;

  localparam logic [4:0] OPC_LUI = 5'b01101, OPC_AUIPC = 5'b00101, OPC_JAL = 5'b11011;
  localparam logic [4:0] OPC_JALR = 5'b11001, OPC_BRANCH = 5'b11000, OPC_LOAD = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000, OPC_OPIMM = 5'b00100, OPC_OP = 5'b01100;

  typedef struct packed {
    logic               illegal;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         alu_srca;
    logic               alu_srcb;
    logic [1:0]         mem_d_wdsrc;
    logic               mem_d_we;
    logic [2:0]         dataout_src;
    logic               reg_we;
    logic [3:0]         immg_op;
    logic [3:0]         bj_op;
    logic               is_mc;
    logic [CNT_W-1:0]   lat_m1;
  } ctrl_t;

  function automatic logic [ALUOP_W-1:0] base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_op = alt ? EXE_SUB_OP : EXE_ADD_OP;
      3'b001:  base_op = EXE_SLL_OP;
      3'b010:  base_op = EXE_SLT_OP;
      3'b011:  base_op = EXE_SLTU_OP;
      3'b100:  base_op = EXE_XOR_OP;
      3'b101:  base_op = alt ? EXE_SRA_OP : EXE_SRL_OP;
      3'b110:  base_op = EXE_OR_OP;
      default: base_op = EXE_AND_OP;
    endcase
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] mc_cnt;
  ctrl_t            held;
  ctrl_t            dec;
  logic [31:0]      pc_q;
  logic             bad;
  logic             accept;
  logic [2:0]       f3;
  logic [6:0]       f7;

  assign f3 = bus.in_instr[14:12];
  assign f7 = bus.in_instr[31:25];

  always_comb begin
    dec = '0;
    bad = 1'b0;
    if (bus.in_instr[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (bus.in_instr[6:2])
        OPC_LUI, OPC_AUIPC: begin
          dec.alu_op      = EXE_ADD_OP;
          dec.alu_srca    = (bus.in_instr[5]) ? SRCA_ZERO : SRCA_PC;
          dec.alu_srcb    = SRCB_IMM;
          dec.immg_op     = IMM_U;
          dec.dataout_src = DOUT_ALU;
          dec.reg_we      = 1'b1;
        end
        OPC_JAL, OPC_JALR: begin
          bad             = bus.in_instr[3] ? 1'b0 : (f3 != 3'b000);
          dec.alu_op      = EXE_ADD_OP;
          dec.alu_srca    = bus.in_instr[3] ? SRCA_PC : SRCA_RRD1;
          dec.alu_srcb    = SRCB_IMM;
          dec.immg_op     = bus.in_instr[3] ? IMM_J : IMM_I;
          dec.dataout_src = DOUT_PC4;
          dec.reg_we      = 1'b1;
          dec.bj_op       = BJOP_JUMP;
        end
        OPC_BRANCH: begin
          bad          = (f3[2:1] == 2'b01);
          dec.alu_op   = EXE_ADD_OP;
          dec.alu_srca = SRCA_PC;
          dec.alu_srcb = SRCB_IMM;
          dec.immg_op  = IMM_B;
          // BEQ,BNE,BLT,BGE,BLTU,BGEU map to consecutive codes once the 01x hole is removed
          dec.bj_op    = BJOP_BEQ + (f3[2] ? {1'b0, f3} - 4'd2 : {1'b0, f3});
        end
        OPC_LOAD: begin
          bad             = (f3 == 3'b011) || (f3[2:1] == 2'b11);
          dec.alu_op      = EXE_ADD_OP;
          dec.alu_srca    = SRCA_RRD1;
          dec.alu_srcb    = SRCB_IMM;
          dec.immg_op     = IMM_I;
          dec.dataout_src = DOUT_LB + (f3[2] ? f3 - 3'd1 : f3);
          dec.reg_we      = 1'b1;
        end
        OPC_STORE: begin
          bad             = (f3 > 3'd2);
          dec.alu_op      = EXE_ADD_OP;
          dec.alu_srca    = SRCA_RRD1;
          dec.alu_srcb    = SRCB_IMM;
          dec.immg_op     = IMM_S;
          dec.mem_d_we    = 1'b1;
          dec.mem_d_wdsrc = f3[1:0] + 2'd1;
        end
        OPC_OPIMM: begin
          bad             = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                            ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
          dec.alu_op      = base_op(f3, (f3 == 3'b101) && f7[5]);
          dec.alu_srca    = SRCA_RRD1;
          dec.alu_srcb    = SRCB_IMM;
          dec.immg_op     = IMM_I;
          dec.dataout_src = DOUT_ALU;
          dec.reg_we      = 1'b1;
        end
        OPC_OP: begin
          dec.alu_srca    = SRCA_RRD1;
          dec.alu_srcb    = SRCB_RRD2;
          dec.dataout_src = DOUT_ALU;
          dec.reg_we      = 1'b1;
          if (f7 == 7'h01) begin
            bad        = (ENABLE_M == 0);
            dec.alu_op = EXE_MUL_OP + ALUOP_W'(f3);
            dec.is_mc  = f3[2] ? (DIV_LAT > 1) : (MUL_LAT > 1);
            dec.lat_m1 = f3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
          end else begin
            bad        = !((f7 == 7'h00) ||
                           ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            dec.alu_op = base_op(f3, f7[5]);
          end
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign bus.in_ready = !bus.flush &&
                        ((state == S_EMPTY) || ((state == S_FULL) && bus.out_ready && !held.is_mc));
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_EMPTY;
      mc_cnt <= '0;
      held   <= '0;
      pc_q   <= '0;
    end else if (bus.flush) begin
      state  <= S_EMPTY;
      mc_cnt <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            held  <= dec;
            pc_q  <= bus.in_pc;
            state <= S_FULL;
          end
        end
        S_FULL: begin
          if (bus.out_ready) begin
            if (held.is_mc) begin
              state  <= S_MCWAIT;
              mc_cnt <= held.lat_m1;
            end else if (accept) begin
              held <= dec;
              pc_q <= bus.in_pc;
            end else begin
              state <= S_EMPTY;
            end
          end
        end
        S_MCWAIT: begin
          mc_cnt <= mc_cnt - CNT_W'(1);
          if (mc_cnt <= CNT_W'(1)) state <= S_EMPTY;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign bus.out_valid   = (state == S_FULL);
  assign bus.out_pc      = pc_q;
  assign bus.illegal     = held.illegal;
  assign bus.alu_op      = held.alu_op;
  assign bus.alu_srca    = held.alu_srca;
  assign bus.alu_srcb    = held.alu_srcb;
  assign bus.mem_d_wdsrc = held.mem_d_wdsrc;
  assign bus.mem_d_we    = held.mem_d_we;
  assign bus.dataout_src = held.dataout_src;
  assign bus.reg_we      = held.reg_we;
  assign bus.immg_op     = held.immg_op;
  assign bus.bj_op       = held.bj_op;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized and directed bench for decode_ctrl_pipe against a queue-based reference model.
module tb_decode_ctrl_pipe;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  decode_ctrl_pipe_if #(.ALUOP_W(5)) bus_m ();
  decode_ctrl_pipe_if #(.ALUOP_W(5)) bus_b ();

  decode_ctrl_pipe #(.ENABLE_M(1), .MUL_LAT(1), .DIV_LAT(4), .ALUOP_W(5)) dut_m (
    .clk(clk), .reset(reset), .bus(bus_m.slave));
  decode_ctrl_pipe #(.ENABLE_M(0), .ALUOP_W(5)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ill;
    logic [4:0] alu;
    logic [1:0] srca;
    logic       srcb;
    logic [1:0] wds;
    logic       mwe;
    logic [2:0] dout;
    logic       we;
    logic [3:0] imm;
    logic [3:0] bj;
  } ctrl_t;

  typedef struct {
    ctrl_t       c;
    logic [31:0] pc;
    int          lat;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected control fields straight from the per-opcode decode table
  function automatic ctrl_t ref_ctrl(input logic [31:0] w, input bit en_m);
    ctrl_t      c;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    int         bjt[8];
    int         ldt[8];
    int         alut[8];
    c    = '0;
    f3   = w[14:12];
    f7   = w[31:25];
    ok   = 1'b1;
    bjt  = '{2, 3, -1, -1, 4, 5, 6, 7};
    ldt  = '{3, 4, 5, -1, 6, 7, -1, -1};
    alut = '{1, 3, 4, 5, 6, 7, 9, 10};
    case (w[6:0])
      7'h37: begin c.alu = 5'd1; c.srcb = 1; c.imm = 4'd4; c.dout = 3'd1; c.we = 1; end
      7'h17: begin c.alu = 5'd1; c.srca = 2'd2; c.srcb = 1; c.imm = 4'd4; c.dout = 3'd1; c.we = 1; end
      7'h6F: begin
        c.alu = 5'd1; c.srca = 2'd2; c.srcb = 1; c.imm = 4'd5; c.dout = 3'd2; c.we = 1; c.bj = 4'd1;
      end
      7'h67: begin
        if (f3 != 0) ok = 1'b0;
        c.alu = 5'd1; c.srca = 2'd1; c.srcb = 1; c.imm = 4'd1; c.dout = 3'd2; c.we = 1; c.bj = 4'd1;
      end
      7'h63: begin
        if (bjt[f3] < 0) ok = 1'b0;
        c.alu = 5'd1; c.srca = 2'd2; c.srcb = 1; c.imm = 4'd3; c.bj = 4'(bjt[f3]);
      end
      7'h03: begin
        if (ldt[f3] < 0) ok = 1'b0;
        c.alu = 5'd1; c.srca = 2'd1; c.srcb = 1; c.imm = 4'd1; c.dout = 3'(ldt[f3]); c.we = 1;
      end
      7'h23: begin
        if (f3 > 2) ok = 1'b0;
        c.alu = 5'd1; c.srca = 2'd1; c.srcb = 1; c.imm = 4'd2; c.mwe = 1; c.wds = 2'(f3 + 1);
      end
      7'h13: begin
        c.alu = 5'(alut[f3]);
        if (f3 == 5 && f7 == 7'h20) c.alu = 5'd8;
        if (f3 == 1 && f7 != 0) ok = 1'b0;
        if (f3 == 5 && f7 != 0 && f7 != 7'h20) ok = 1'b0;
        c.srca = 2'd1; c.srcb = 1; c.imm = 4'd1; c.dout = 3'd1; c.we = 1;
      end
      7'h33: begin
        if (f7 == 7'h01) begin
          if (!en_m) ok = 1'b0;
          c.alu = 5'(11 + int'(f3));
        end else if (f7 == 7'h00) begin
          c.alu = 5'(alut[f3]);
        end else if (f7 == 7'h20 && f3 == 0) begin
          c.alu = 5'd2;
        end else if (f7 == 7'h20 && f3 == 5) begin
          c.alu = 5'd8;
        end else begin
          ok = 1'b0;
        end
        c.srca = 2'd1; c.dout = 3'd1; c.we = 1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      c     = '0;
      c.ill = 1'b1;
    end
    return c;
  endfunction

  function automatic int ref_lat(input logic [31:0] w);
    if (w[6:0] == 7'h33 && w[31:25] == 7'h01) return w[14] ? 4 : 1;
    return 1;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    logic [6:0]  opcs[11];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h13, 7'h33, 7'h33};
    w = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) w[6:0] = opcs[k];
    if (k == 3 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
    if (k >= 7 && k <= 10) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  ent_t        q[$];
  int          stall;
  logic        exp_rdy;
  ent_t        e;
  ctrl_t       dut_c;

  // Reference model: at most one decoded op in flight, plus a post-handshake stall count for M ops
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stall = 0;
    end else begin
      exp_rdy = !bus_m.flush && (stall == 0) &&
                ((q.size() == 0) || (bus_m.out_ready && q[0].lat <= 1));
      chk("in_ready", {31'd0, bus_m.in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, bus_m.out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0 && bus_m.out_valid) begin
        dut_c = '{bus_m.illegal, bus_m.alu_op, bus_m.alu_srca, bus_m.alu_srcb, bus_m.mem_d_wdsrc,
                  bus_m.mem_d_we, bus_m.dataout_src, bus_m.reg_we, bus_m.immg_op, bus_m.bj_op};
        chk("ctrl", {8'd0, dut_c}, {8'd0, q[0].c});
        chk("out_pc", bus_m.out_pc, q[0].pc);
      end
      if (bus_m.flush) begin
        q.delete();
        stall = 0;
      end else begin
        if (stall > 0) stall--;
        if (q.size() > 0 && bus_m.out_ready) begin
          e = q.pop_front();
          if (e.lat > 1) stall = e.lat - 1;
        end
        if (bus_m.in_valid && exp_rdy) begin
          e.c   = ref_ctrl(bus_m.in_instr, 1'b1);
          e.pc  = bus_m.in_pc;
          e.lat = ref_lat(bus_m.in_instr);
          q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    bus_m.in_valid = 1'b1;
    bus_m.in_instr = w;
    bus_m.in_pc    = pc;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    stall       = 0;
    reset       = 1'b1;
    bus_m.flush = 0; bus_m.in_valid = 0; bus_m.in_instr = 0; bus_m.in_pc = 0; bus_m.out_ready = 1;
    bus_b.flush = 0; bus_b.in_valid = 0; bus_b.in_instr = 0; bus_b.in_pc = 0; bus_b.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus_m.out_valid}, 32'd0);
    chk("rst_fields", {bus_m.illegal, bus_m.alu_op, bus_m.bj_op, bus_m.reg_we}, 32'd0);
    chk("rst_out_pc", bus_m.out_pc, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, bus_m.in_ready}, 32'd1);

    // addi x1,x0,5
    send(32'h00500093, 32'h100);
    step();
    bus_m.in_valid = 0;
    #1;
    chk("addi_valid", {31'd0, bus_m.out_valid}, 32'd1);
    chk("addi_fields", {bus_m.illegal, bus_m.alu_op, bus_m.alu_srca, bus_m.alu_srcb, bus_m.immg_op, bus_m.reg_we},
        {1'b0, 5'd1, 2'd1, 1'b1, 4'd1, 1'b1});

    // sub, then sub with funct7=0x10 (illegal), back to back
    step();
    send(32'h402081B3, 32'h104);
    step();
    bus_m.in_instr = 32'h202081B3;
    #1;
    chk("sub_op", {bus_m.illegal, bus_m.alu_op}, {1'b0, 5'd2});
    step();
    bus_m.in_valid = 0;
    #1;
    chk("bad_sub", {bus_m.illegal, bus_m.reg_we, bus_m.mem_d_we, bus_m.bj_op}, {1'b1, 1'b0, 1'b0, 4'd0});

    // div with DIV_LAT=4: three stall cycles after the output handshake
    step();
    send(32'h0220C1B3, 32'h108);
    step();
    bus_m.in_valid = 0;
    #1;
    chk("div_op", {bus_m.out_valid, bus_m.illegal, bus_m.alu_op}, {1'b1, 1'b0, 5'd15});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("div_stall", {31'd0, bus_m.in_ready}, 32'd0);
    end
    step();
    chk("div_release", {31'd0, bus_m.in_ready}, 32'd1);

    // out_ready low for 5 cycles with a waiting input
    send(32'h00A00113, 32'h200);
    bus_m.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      send(32'h00108093, 32'h204);
      #1;
      chk("hold_pc", bus_m.out_pc, 32'h200);
      chk("hold_rdy", {31'd0, bus_m.in_ready}, 32'd0);
    end
    step();
    bus_m.out_ready = 1;
    #1;
    chk("hold_release_rdy", {31'd0, bus_m.in_ready}, 32'd1);
    step();
    bus_m.in_valid = 0;
    #1;
    chk("hold_next_pc", bus_m.out_pc, 32'h204);

    // flush while mc_cnt==2
    step();
    send(32'h0220C1B3, 32'h300);
    step();
    bus_m.in_valid = 0;
    step();
    step();
    bus_m.flush = 1;
    send(32'h00500093, 32'h400);
    #1;
    chk("flush_rdy", {31'd0, bus_m.in_ready}, 32'd0);
    step();
    bus_m.flush = 0;
    bus_m.in_valid = 0;
    #1;
    chk("flush_state", {30'd0, bus_m.out_valid, bus_m.in_ready}, {30'd0, 1'b0, 1'b1});
    step();
    chk("flush_drop", {31'd0, bus_m.out_valid}, 32'd0);

    // zero word, lw funct3=011, jalr
    send(32'h00000000, 32'h500);
    step();
    bus_m.in_instr = 32'h0000B083;
    #1;
    chk("zero_ill", {31'd0, bus_m.illegal}, 32'd1);
    step();
    bus_m.in_instr = 32'h000080E7;
    #1;
    chk("ld011_ill", {31'd0, bus_m.illegal}, 32'd1);
    step();
    bus_m.in_valid = 0;
    #1;
    chk("jalr", {bus_m.illegal, bus_m.immg_op, bus_m.bj_op, bus_m.dataout_src}, {1'b0, 4'd1, 4'd1, 3'd2});

    // asynchronous reset in the middle of MCWAIT
    step();
    send(32'h0220C1B3, 32'h600);
    step();
    bus_m.in_valid = 0;
    step();
    step();
    chk("mc_before_rst", {31'd0, bus_m.in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {bus_m.in_ready, bus_m.out_valid, bus_m.alu_op}, {1'b1, 1'b0, 5'd0});
    @(negedge clk);
    #2 reset = 1'b0;

    // ENABLE_M=0 instance: div is illegal and never stalls
    step();
    bus_b.in_valid = 1; bus_b.in_instr = 32'h0220C1B3; bus_b.in_pc = 32'h700;
    step();
    bus_b.in_valid = 0;
    #1;
    chk("nom_div", {bus_b.out_valid, bus_b.illegal, bus_b.reg_we, bus_b.alu_op}, {1'b1, 1'b1, 1'b0, 5'd0});
    step();
    chk("nom_rdy", {31'd0, bus_b.in_ready}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      step();
      bus_m.in_valid  = ($urandom_range(0, 9) < 7);
      bus_m.in_instr  = rand_instr();
      bus_m.in_pc     = $urandom;
      bus_m.out_ready = ($urandom_range(0, 3) != 0);
      bus_m.flush     = ($urandom_range(0, 49) == 0);
    end
    step();
    bus_m.in_valid = 0; bus_m.flush = 0; bus_m.out_ready = 1;
    repeat (8) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered, handshaked instruction decoder for the Zeptron core, sitting between the fetch stage and the execute stage. Decodes RV32I, plus RV32M when `ENABLE_M=1`, into the execute control fields. Flags illegal encodings explicitly and drives defined zeros instead of don't-cares. Stalls upstream while a multi-cycle multiply/divide occupies execute, counting its latency internally.

## Interface
- `ENABLE_M`, 0: 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 flags them illegal.
- `MUL_LAT`, 1: execute cycles for multiply-class ops (≥1).
- `DIV_LAT`, 32: execute cycles for divide/remainder-class ops (≥1).
- `ALUOP_W`, 5: alu_op width. Holds EXE_*_OP codes including EXE_MUL_OP..EXE_REMU_OP.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous squash. Highest priority after reset.
- `in_valid` / `in_ready` in/out 1: fetch handshake.
- `in_instr` in 32; `in_pc` in 32.
- `out_valid` / `out_ready` out/in 1: execute handshake.
- `out_pc` out 32; `illegal` out 1.
- `alu_op` out ALUOP_W; `alu_srca` out 2; `alu_srcb` out 1; `mem_d_wdsrc` out 2; `mem_d_we` out 1; `dataout_src` out 3; `reg_we` out 1; `immg_op` out 4; `bj_op` out 4.

## Operation
- States: EMPTY, FULL, MCWAIT. Down-counter `mc_cnt` is $clog2(DIV_LAT+1) bits wide.
- Input acceptance is `in_valid && in_ready`.
- `in_ready` = (EMPTY) || (FULL && out_ready && !out_is_mc). It is 0 in MCWAIT.
- `out_is_mc` is set when the held op is M-class with latency >1.
- Transitions:
  - EMPTY: on accept, capture the decode and go to FULL.
  - FULL, out_ready=0: hold all outputs stable.
  - FULL, out_ready=1, held op multi-cycle: go to MCWAIT and load `mc_cnt` = LAT−1.
  - FULL, out_ready=1, otherwise: capture the next input if accepted (stay FULL), else go to EMPTY.
  - MCWAIT: decrement `mc_cnt`. When it reaches 0, go to EMPTY.
- `out_valid` = (state==FULL).
- `flush`: state←EMPTY, `mc_cnt`←0, `out_valid`←0, `in_ready`=0 that cycle. A simultaneous input is dropped.
- Decode map. Every field unused by an op is driven to 0.
  - LUI: ADD, ZERO+IMM, U.
  - AUIPC: ADD, PC+IMM, U.
  - JAL: PC+IMM, J, dataout PC4, BJOP_JUMP.
  - JALR: RRD1+IMM, I-type, PC4, JUMP.
  - BRANCH: PC+IMM, B-type, bj_op from funct3.
  - LOAD: dataout from funct3.
  - STORE: mem_d_we=1, wdsrc from funct3.
  - OP-IMM / OP: alu_op from funct3/funct7.
  - M ops: RRD1+RRD2, reg_we=1.
- Illegal when any of the following holds:
  - in_instr[1:0]≠2'b11, or the opcode is unlisted.
  - JALR funct3≠0.
  - Branch funct3 010/011.
  - Load funct3 011/110/111.
  - Store funct3≥3.
  - SLLI funct7≠0; SRLI/SRAI funct7 ∉ {0x00, 0x20}.
  - OP with funct7 ∉ {0x00, 0x20 (ADD/SUB and SRL/SRA only), 0x01 (only if ENABLE_M)}.
- Illegal response: `illegal`=1, reg_we=0, mem_d_we=0, bj_op=EXE_BJOP_NOOP, other fields 0, `out_valid` still asserted. Trap handling lies downstream.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1 after reset release. `illegal`, `out_pc`, all control fields, and `mc_cnt` are 0.
- Latency: one cycle from input handshake to `out_valid`. Throughput is 1/cycle for non-M ops.
- M op with latency L>1: `in_ready` is low for exactly L−1 cycles after its output handshake. The next input can be accepted on the cycle after that.
- MUL_LAT=1 or DIV_LAT=1 behaves as a single-cycle op with no MCWAIT entry.
- Outputs are registered, with no combinational path from `in_instr` to the outputs. `in_ready` depends combinationally on `out_ready`.
- Reset asserted mid-MCWAIT returns to the reset state immediately, asynchronously.

## Test plan
- `addi x1,x0,5` (0x00500093) → next cycle: out_valid=1, alu_op=EXE_ADD_OP, alu_srca=RRD1, alu_srcb=IMM, immg_op=I, reg_we=1, illegal=0.
- Back-to-back `sub x3,x1,x2` (0x402081B3) then 0x202081B3 with out_ready=1 → first: EXE_SUB_OP, illegal=0. Second: illegal=1, reg_we=0, mem_d_we=0.
- ENABLE_M=1, DIV_LAT=4, `div x3,x1,x2` (0x0220C1B3) → alu_op=EXE_DIV_OP. After its output handshake, in_ready=0 for 3 cycles, then 1. With ENABLE_M=0 the same word gives illegal=1.
- out_ready held 0 for 5 cycles with in_valid=1 → outputs stable and only one instruction accepted. Release → the next instruction appears one cycle later.
- flush asserted in MCWAIT with mc_cnt=2 → next cycle state EMPTY, out_valid=0, in_ready=1.
- Word 0x00000000, then `lw` with funct3=011 (0x0000B083) → both give illegal=1. `jalr` (0x000080E7) → immg_op=I, bj_op=JUMP, dataout_src=PC4.
